// File: rtl/hdd_image_server.sv
// hdd_image_server: serves 512-byte blocks between a sector buffer and a backing image memory.
// Optional write protection via `HDD_SERVER_WP_EN (uses img_readonly when defined).
module hdd_image_server #(
  parameter int ACK_DELAY = 16,
  parameter int BLOCK_BYTES = 512
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        rd_req,
  input  logic        wr_req,
  input  logic [31:0] lba,
  input  logic [15:0] img_blocks,
  input  logic        img_readonly,
  output logic        ack,
  output logic [8:0]  buff_addr,
  output logic [7:0]  buff_dout,
  output logic        buff_wr,
  input  logic [7:0]  buff_din,
  output logic [24:0] img_addr,
  output logic        img_rd,
  output logic        img_wr,
  input  logic [7:0]  img_din,
  output logic [7:0]  img_dout,
  input  logic        img_ready,
  output logic        err
);
  typedef enum logic [2:0] {IDLE, DELAY, XFER_ADDR, XFER_WAIT, XFER_PUT, DONE} state_t;
  state_t state, state_nx;
  logic [15:0] lba_q;
  logic [8:0] idx;
  logic [7:0] cnt, data_q;
  logic is_wr, skip, oor, wp, unused;
  assign oor = lba[15:0] >= img_blocks;
`ifdef HDD_SERVER_WP_EN
  assign wp = wr_req && !rd_req && img_readonly;
`else
  assign wp = 1'b0;
`endif
  assign unused = ^{lba[31:16], img_readonly};
  always_ff @(posedge clk_sys) begin
    if (reset) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      state_nx = (rd_req || wr_req) ? DELAY : IDLE;
      DELAY:     state_nx = (cnt == 8'(ACK_DELAY - 1)) ? XFER_ADDR : DELAY;
      XFER_ADDR: state_nx = (skip || (!is_wr && img_ready)) ? XFER_PUT : XFER_WAIT;
      XFER_WAIT: state_nx = (cnt != 8'd0 && img_ready) ? XFER_PUT : XFER_WAIT;
      XFER_PUT:  state_nx = (idx == 9'(BLOCK_BYTES - 1)) ? DONE : XFER_ADDR;
      default:   state_nx = IDLE;
    endcase
  end
  // In XFER_WAIT, cnt sequences writes: 0 = capture buff_din, 1 = img_wr strobe, 2 = await ready.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      lba_q <= '0;
      idx <= '0;
      cnt <= '0;
      data_q <= '0;
      is_wr <= 1'b0;
      skip <= 1'b0;
      err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (rd_req || wr_req) begin
          lba_q <= lba[15:0];
          is_wr <= !rd_req;
          skip <= oor || wp;
          err <= err || oor || wp;
          cnt <= '0;
        end
        DELAY: cnt <= cnt + 8'd1;
        XFER_ADDR: begin
          cnt <= {7'd0, !is_wr};
          data_q <= skip ? 8'd0 : (!is_wr && img_ready) ? img_din : data_q;
        end
        XFER_WAIT: begin
          cnt <= (cnt < 8'd2) ? cnt + 8'd1 : cnt;
          data_q <= (cnt == 8'd0) ? buff_din : (!is_wr && img_ready) ? img_din : data_q;
        end
        XFER_PUT: idx <= idx + 9'd1;
        default: ;
      endcase
    end
  end
  always_comb begin
    ack = state == XFER_ADDR || state == XFER_WAIT || state == XFER_PUT;
    img_rd = state == XFER_ADDR && !is_wr && !skip;
    img_wr = state == XFER_WAIT && is_wr && cnt == 8'd1;
    buff_wr = state == XFER_PUT && !is_wr;
    buff_addr = idx;
    buff_dout = data_q;
    img_dout = data_q;
    img_addr = {lba_q, idx};
  end
endmodule

// File: tb/tb_hdd_image_server.sv
// tb_hdd_image_server: scoreboard bench for hdd_image_server with buffer and latency-configurable image models.
module tb_hdd_image_server;
  localparam int ACK_DELAY = 16;
  typedef logic [34:0] ev_t;
  logic clk_sys = 1'b0, reset = 1'b1, rd_req = 1'b0, wr_req = 1'b0, img_readonly = 1'b0;
  logic [31:0] lba = '0;
  logic [15:0] img_blocks = 16'd100;
  logic ack, buff_wr, img_rd, img_wr, img_ready, err;
  logic [8:0] buff_addr;
  logic [7:0] buff_dout, buff_din = '0, img_din, img_dout;
  logic [24:0] img_addr;
  logic [7:0] bmem [512];
  int lat = 0, ready_cnt = 0, n_rd = 0, n_viol = 0, tests = 0, fails = 0;
  logic pbw = 1'b0, prd = 1'b0, pwr = 1'b0;
  ev_t obs[$], exp_q[$];

  hdd_image_server #(.ACK_DELAY(ACK_DELAY)) dut (
    .clk_sys(clk_sys), .reset(reset), .rd_req(rd_req), .wr_req(wr_req), .lba(lba),
    .img_blocks(img_blocks), .img_readonly(img_readonly), .ack(ack), .buff_addr(buff_addr),
    .buff_dout(buff_dout), .buff_wr(buff_wr), .buff_din(buff_din), .img_addr(img_addr),
    .img_rd(img_rd), .img_wr(img_wr), .img_din(img_din), .img_dout(img_dout),
    .img_ready(img_ready), .err(err)
  );

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) buff_din <= bmem[buff_addr];
  always @(posedge clk_sys)
    if ((img_rd || img_wr) && lat > 0) ready_cnt <= lat;
    else if (ready_cnt > 0) ready_cnt <= ready_cnt - 1;
  assign img_ready = (lat == 0) ? (img_rd | img_wr) : (ready_cnt == 1);
  assign img_din = img_addr[7:0];

  always @(negedge clk_sys) begin
    if (buff_wr) obs.push_back({2'd0, 16'd0, buff_addr, buff_dout});
    if (img_wr) obs.push_back({2'd1, img_addr, img_dout});
    if (img_rd) n_rd++;
    if ((buff_wr && (img_rd || img_wr)) || (buff_wr && pbw) || (img_rd && prd) || (img_wr && pwr)) n_viol++;
    pbw <= buff_wr;
    prd <= img_rd;
    pwr <= img_wr;
  end

  task automatic do_reset;
    @(negedge clk_sys);
    reset = 1'b1;
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    reset = 1'b0;
  endtask

  task automatic xfer(input bit rd, input bit wr, input logic [31:0] l, output int dly, output bit tmo);
    @(negedge clk_sys);
    rd_req = rd;
    wr_req = wr;
    lba = l;
    @(posedge clk_sys);
    #1;
    rd_req = 1'b0;
    wr_req = 1'b0;
    dly = 1;
    while (!ack && dly < 1000) begin @(posedge clk_sys); #1; dly++; end
    for (int c = 0; ack && c < 20000; c++) begin @(posedge clk_sys); #1; end
    tmo = ack || dly >= 1000;
    repeat (3) @(posedge clk_sys);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk_sys);
    #1;
    tests++;
    if ({ack, buff_wr, img_rd, img_wr, err} !== 5'b0) begin
      fails++;
      $display("FAIL reset_ctrl got %b exp 00000", {ack, buff_wr, img_rd, img_wr, err});
    end
    tests++;
    if ({buff_addr, buff_dout, img_addr, img_dout} !== 50'b0) begin
      fails++;
      $display("FAIL reset_data got %h exp 0", {buff_addr, buff_dout, img_addr, img_dout});
    end
    @(negedge clk_sys);
    reset = 1'b0;
  endtask

  task automatic test_read;
    int s = obs.size(), r0 = n_rd, v0 = n_viol, dly;
    bit tmo;
    lat = 2;
    for (int i = 0; i < 512; i++) exp_q.push_back({2'd0, 16'd0, 9'(i), 8'(i)});
    xfer(1'b1, 1'b0, 32'd5, dly, tmo);
    tests++;
    if (tmo || dly != ACK_DELAY + 1) begin fails++; $display("FAIL read_ack_delay got %0d tmo %0d exp %0d", dly, tmo, ACK_DELAY + 1); end
    tests++;
    if (obs.size() - s != 512) begin fails++; $display("FAIL read_count got %0d exp 512", obs.size() - s); end
    for (int i = 0; i < 512 && s + i < obs.size(); i++) begin
      ev_t e = exp_q.pop_front();
      tests++;
      if (obs[s + i] !== e) begin fails++; $display("FAIL read_ev%0d got %h exp %h", i, obs[s + i], e); end
    end
    exp_q.delete();
    tests++;
    if (n_rd - r0 != 512) begin fails++; $display("FAIL read_img_rd got %0d exp 512", n_rd - r0); end
    tests++;
    if (err !== 1'b0 || n_viol != v0) begin fails++; $display("FAIL read_err_viol got %b/%0d exp 0/0", err, n_viol - v0); end
  endtask

  task automatic test_write;
    int s = obs.size(), r0 = n_rd, dly;
    bit tmo;
    lat = 3;
    for (int i = 0; i < 512; i++) exp_q.push_back({2'd1, 25'h400 + 25'(i), ~8'(i)});
    xfer(1'b0, 1'b1, 32'hABCD_0002, dly, tmo);
    tests++;
    if (tmo) begin fails++; $display("FAIL write_timeout got 1 exp 0"); end
    tests++;
    if (obs.size() - s != 512) begin fails++; $display("FAIL write_count got %0d exp 512", obs.size() - s); end
    for (int i = 0; i < 512 && s + i < obs.size(); i++) begin
      ev_t e = exp_q.pop_front();
      tests++;
      if (obs[s + i] !== e) begin fails++; $display("FAIL write_ev%0d got %h exp %h", i, obs[s + i], e); end
    end
    exp_q.delete();
    tests++;
    if (n_rd != r0 || err !== 1'b0) begin fails++; $display("FAIL write_rd_err got %0d/%b exp 0/0", n_rd - r0, err); end
  endtask

  task automatic test_both;
    int s = obs.size(), dly;
    bit tmo;
    lat = 0;
    for (int i = 0; i < 512; i++) exp_q.push_back({2'd0, 16'd0, 9'(i), 8'(i)});
    xfer(1'b1, 1'b1, 32'd7, dly, tmo);
    tests++;
    if (tmo || obs.size() - s != 512) begin fails++; $display("FAIL both_count got %0d tmo %0d exp 512", obs.size() - s, tmo); end
    for (int i = 0; i < 512 && s + i < obs.size(); i++) begin
      ev_t e = exp_q.pop_front();
      tests++;
      if (obs[s + i] !== e) begin fails++; $display("FAIL both_ev%0d got %h exp %h", i, obs[s + i], e); end
    end
    exp_q.delete();
  endtask

  task automatic test_reset_mid;
    int s = obs.size(), s2, r1, dly, c = 0;
    bit tmo;
    lat = 1;
    @(negedge clk_sys);
    rd_req = 1'b1;
    lba = 32'd3;
    @(posedge clk_sys);
    #1;
    rd_req = 1'b0;
    while (obs.size() - s < 200 && c < 5000) begin @(negedge clk_sys); c++; end
    tests++;
    if (obs.size() - s != 200) begin fails++; $display("FAIL mid_reach200 got %0d exp 200", obs.size() - s); end
    reset = 1'b1;
    @(posedge clk_sys);
    #1;
    tests++;
    if ({ack, buff_wr, img_rd, img_wr} !== 4'b0) begin fails++; $display("FAIL mid_after_reset got %b exp 0000", {ack, buff_wr, img_rd, img_wr}); end
    s2 = obs.size();
    r1 = n_rd;
    repeat (2) @(posedge clk_sys);
    @(negedge clk_sys);
    reset = 1'b0;
    repeat (6) @(posedge clk_sys);
    @(negedge clk_sys);
    tests++;
    if (obs.size() != s2 || n_rd != r1 || ack !== 1'b0) begin fails++; $display("FAIL mid_quiet got %0d/%0d/%b exp 0/0/0", obs.size() - s2, n_rd - r1, ack); end
    s = obs.size();
    for (int i = 0; i < 512; i++) exp_q.push_back({2'd0, 16'd0, 9'(i), 8'(i)});
    xfer(1'b1, 1'b0, 32'd9, dly, tmo);
    tests++;
    if (tmo || obs.size() - s != 512) begin fails++; $display("FAIL mid_rerun_count got %0d tmo %0d exp 512", obs.size() - s, tmo); end
    for (int i = 0; i < 512 && s + i < obs.size(); i++) begin
      ev_t e = exp_q.pop_front();
      tests++;
      if (obs[s + i] !== e) begin fails++; $display("FAIL mid_ev%0d got %h exp %h", i, obs[s + i], e); end
    end
    exp_q.delete();
  endtask

  task automatic test_readonly;
    int s = obs.size(), dly;
    bit tmo;
    lat = 0;
    img_readonly = 1'b1;
    xfer(1'b0, 1'b1, 32'd4, dly, tmo);
    img_readonly = 1'b0;
    tests++;
    if (tmo || dly != ACK_DELAY + 1) begin fails++; $display("FAIL ro_ack got %0d tmo %0d exp %0d", dly, tmo, ACK_DELAY + 1); end
`ifdef HDD_SERVER_WP_EN
    tests++;
    if (obs.size() != s || err !== 1'b1) begin fails++; $display("FAIL ro_wp got %0d/%b exp 0/1", obs.size() - s, err); end
`else
    tests++;
    if (obs.size() - s != 512 || err !== 1'b0) begin fails++; $display("FAIL ro_ignored got %0d/%b exp 512/0", obs.size() - s, err); end
    for (int i = 0; i < 512 && s + i < obs.size(); i++) begin
      ev_t e = {2'd1, 25'h800 + 25'(i), ~8'(i)};
      tests++;
      if (obs[s + i] !== e) begin fails++; $display("FAIL ro_ev%0d got %h exp %h", i, obs[s + i], e); end
    end
`endif
  endtask

  task automatic test_oor;
    int s, r0, dly;
    bit tmo;
    do_reset();
    tests++;
    if (err !== 1'b0) begin fails++; $display("FAIL oor_err_cleared got %b exp 0", err); end
    s = obs.size();
    r0 = n_rd;
    lat = 0;
    img_blocks = 16'd100;
    for (int i = 0; i < 512; i++) exp_q.push_back({2'd0, 16'd0, 9'(i), 8'h00});
    xfer(1'b1, 1'b0, 32'd100, dly, tmo);
    tests++;
    if (tmo || obs.size() - s != 512) begin fails++; $display("FAIL oor_count got %0d tmo %0d exp 512", obs.size() - s, tmo); end
    for (int i = 0; i < 512 && s + i < obs.size(); i++) begin
      ev_t e = exp_q.pop_front();
      tests++;
      if (obs[s + i] !== e) begin fails++; $display("FAIL oor_ev%0d got %h exp %h", i, obs[s + i], e); end
    end
    exp_q.delete();
    tests++;
    if (n_rd != r0 || err !== 1'b1) begin fails++; $display("FAIL oor_rd_err got %0d/%b exp 0/1", n_rd - r0, err); end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) bmem[i] = ~8'(i);
    test_reset();
    test_read();
    test_write();
    test_both();
    test_reset_mid();
    test_readonly();
    test_oor();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/hdd_image_server.md
HDD_IMAGE_SERVER -- requirements
Module: hdd_image_server

Interface
REQ-001 Parameter ACK_DELAY, default 16, meaning: idle cycles between request latch and ack rise (legal range 1..255).
REQ-002 Parameter BLOCK_BYTES, default 512, meaning: bytes per block, fixed; buff_addr is 9 bits.
REQ-003 clk_sys  in  1  system clock; all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 rd_req, wr_req  in  1 each  block read / write request levels from the HDD handshake stage.
REQ-006 lba  in  32  block number; only bits [15:0] are used.
REQ-007 img_blocks  in  16  image size in blocks; 0 means no image.
REQ-008 img_readonly  in  1  write-protect input; used only under HDD_SERVER_WP_EN.
REQ-009 ack  out  1  transfer-in-progress acknowledge.
REQ-010 buff_addr  out  9  sector buffer byte index.
REQ-011 buff_dout  out  8  read data to the sector buffer.
REQ-012 buff_wr  out  1  one-cycle sector buffer write strobe.
REQ-013 buff_din  in  8  write data from the sector buffer; valid 1 cycle after buff_addr changes.
REQ-014 img_addr  out  25  byte address into the backing image memory.
REQ-015 img_rd, img_wr  out  1 each  image memory strobes, one cycle each.
REQ-016 img_din  in  8  image read data; valid when img_ready is high.
REQ-017 img_dout  out  8  image write data.
REQ-018 img_ready  in  1  image access complete; may go high in the same cycle as the strobe or later.
REQ-019 err  out  1  sticky flag; set on an out-of-range LBA; cleared only by reset.

Function
REQ-020 States: IDLE, DELAY, XFER_ADDR, XFER_WAIT, XFER_PUT, DONE.
REQ-021 IDLE: on (rd_req|wr_req) latch lba[15:0] and the direction, then go to DELAY.
  - rd_req wins if both requests are high.
  - Requests are sampled only in IDLE.
REQ-022 DELAY: count ACK_DELAY cycles, then raise ack and go to XFER_ADDR with byte index i=0.
REQ-023 img_addr = {lba[15:0], i[8:0]}; the arithmetic is exact 25-bit with no wrap.
REQ-024 Read, in-range LBA:
  - XFER_ADDR pulses img_rd.
  - XFER_WAIT holds until img_ready.
  - XFER_PUT drives buff_addr=i and buff_dout=img_din, and pulses buff_wr.
REQ-025 Write, in-range LBA:
  - XFER_ADDR drives buff_addr=i.
  - XFER_WAIT captures buff_din after one cycle and pulses img_wr with img_dout=buff_din, then holds until img_ready.
  - XFER_PUT advances the index.
REQ-026 Out of range (lba[15:0] >= img_blocks): set err; no img_rd/img_wr pulses.
  - Reads write 0x00 to all 512 buffer bytes.
  - Writes run the index sequence with no image access.
REQ-027 After i=511 completes, the 9-bit index wraps to 0 and the FSM goes to DONE.
  - DONE drops ack for exactly one cycle, then returns to IDLE.
REQ-028 ack stays high continuously from the DELAY exit to DONE; transfer length is always 512 bytes.
REQ-029 buff_wr and img_rd/img_wr are never high in the same cycle, and each is never high for 2 consecutive cycles.
REQ-030 If a request is still high on return to IDLE, it starts a new transfer; no edge detection.

Reset
REQ-031 reset forces, on the next edge:
  - state=IDLE;
  - ack, buff_wr, img_rd, img_wr, err = 0;
  - buff_addr, buff_dout, img_addr, img_dout = 0;
  - counters = 0.
REQ-032 A reset during XFER abandons the transfer; no further strobes are issued, and ack is low the cycle after reset.

Configuration
REQ-033 Macro HDD_SERVER_WP_EN.
  - Defined: a write accepted while img_readonly=1 runs the full ack/index sequence, never pulses img_wr, and sets err.
  - Undefined: img_readonly is ignored.

Verification
REQ-034 img_blocks=100, rd_req pulse with lba=5, image byte n = n[7:0] -> after 16 cycles ack rises; buffer receives 512 writes with buff_dout = 0x00..0xFF twice; ack falls; err=0.
REQ-035 wr_req with lba=2, buffer holds byte i = ~i[7:0], img_ready delayed 3 cycles -> img_wr at addresses 0x400..0x5FF with data ~i; exactly 512 img_wr pulses.
REQ-036 lba=100, img_blocks=100, rd_req -> 512 buff_wr pulses with 0x00; zero img_rd pulses; err=1.
REQ-037 rd_req and wr_req both high -> read transfer only; zero img_wr pulses.
REQ-038 reset asserted at byte 200 of a read -> ack=0 and no strobes from the next cycle; a subsequent rd_req completes a full 512-byte read.
REQ-039 With HDD_SERVER_WP_EN, img_readonly=1, wr_req -> ack sequence completes, 0 img_wr pulses, err=1.
